reflet_gpio_port: RTL and testbench
===================================

Name: reflet_gpio_port

Overview:
- 16-bit general-purpose I/O peripheral on the 8-bit Reflet system bus.
- Exposes 16 synchronized inputs (gpi) as read-only bytes and 16 registered outputs (gpo) as read/write bytes.
- Sits beside the ROM behind a one-bit chip-select decode.
- Read data is zero when the block is not selected, so bus slaves can be wire-ORed into the CPU data input.

Parameters:
- wordsize, 8: bus data width; only 8 is supported.
- base_addr_size, 7: width of the addr port in bits.
- base_addr, 7'h00: base of the 4-byte register window; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  chip select from the upper-level address decode.
- addr  input  base_addr_size  byte address within the peripheral space.
- write_en  input  1  bus write strobe.
- data_in  input  wordsize  write data from CPU.
- data_out  output  wordsize  read data; 0 when not selected.
- gpi  input  16  asynchronous external inputs.
- gpo  output  16  registered outputs.

Behaviour:
- Select: sel = enable && addr[base_addr_size-1:2] == base_addr[base_addr_size-1:2].
- Register map (offset = addr[1:0]):
  - 0: gpi[7:0], read-only.
  - 1: gpi[15:8], read-only.
  - 2: gpo[7:0], read/write.
  - 3: gpo[15:8], read/write.
- Reads are combinational (zero latency). data_out = selected byte when sel, else 8'h00. write_en does not gate reads.
- Writes occur on the rising clk edge when sel && write_en. Offset 2 or 3 loads data_in into the addressed gpo byte; the other byte is unchanged.
- Writes to offsets 0 and 1 are ignored with no side effect.
- gpi passes through a two-flop synchronizer per bit. A gpi change becomes readable after at most 2 rising edges. Offsets 0 and 1 return the synchronized value, never raw gpi.
- gpo is driven directly from its register; a write is visible on gpo right after the writing edge.
- Reset (asynchronous, immediate, any cycle including mid-write): gpo = 16'h0000, synchronizer flops = 0. While reset is high, writes are blocked. data_out stays combinational (0 when not selected; sync value 0 for offsets 0/1).
- Reset released mid-write: no write happens until the first rising edge with reset low.
- enable low: data_out = 0 and writes are ignored, regardless of addr.
- Address outside the window: behaves as not selected.
- Simultaneous gpi change and read: returns the previously synchronized value.

Decomposition:
- Shared package: offset constants GPIO_IN_LO = 2'd0, GPIO_IN_HI = 2'd1, GPIO_OUT_LO = 2'd2, GPIO_OUT_HI = 2'd3; GPIO_WIDTH = 16.
- One natural sub-module: reflet_sync2, a parameterizable-width two-flop synchronizer with async active-high reset, used for gpi.

Test Plan:
- Reset: assert reset with gpo previously 16'h1234 → gpo = 16'h0000 immediately, without waiting for a clock; data_out = 0 with enable = 0.
- Write path: write 8'h80 to offset 3, then 8'h0F to offset 2 → gpo = 16'h8000 after the first edge, 16'h800F after the second. Read offsets 2 and 3 → 8'h0F and 8'h80.
- Input path: set gpi = 16'hABCD, wait 2 edges → offset 0 reads 8'hCD, offset 1 reads 8'hAB. At 1 edge after the change, old values are returned.
- Isolation: enable = 0 with write_en = 1 to offset 2, data 8'hFF → gpo unchanged, data_out = 8'h00. Write 8'h55 to offset 0 → no change anywhere.
- Address decode (base_addr = 7'h10): access to addr 7'h12 selects offset 2. Access to 7'h02 is ignored and data_out = 0.
- Reset mid-operation: raise reset between two writes → gpo = 0; the next write after release updates only the addressed byte.

Source files
------------

// File: rtl/reflet_gpio_port_pkg.sv
// Shared constants for the Reflet GPIO port: register offsets and port widths.
package reflet_gpio_port_pkg;

    localparam int unsigned GPIO_WIDTH = 16;
    localparam int unsigned BYTE_W     = 8;

    localparam logic [1:0] GPIO_IN_LO  = 2'd0;
    localparam logic [1:0] GPIO_IN_HI  = 2'd1;
    localparam logic [1:0] GPIO_OUT_LO = 2'd2;
    localparam logic [1:0] GPIO_OUT_HI = 2'd3;

endpackage

// File: rtl/reflet_sync2.sv
// Two-flop synchronizer for asynchronous inputs, width-parameterizable.
module reflet_sync2 #(
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/reflet_gpio_port.sv
// 16-bit GPIO peripheral on the 8-bit Reflet bus: synchronized inputs at
// offsets 0/1, read/write output register at offsets 2/3.
module reflet_gpio_port
    import reflet_gpio_port_pkg::*;
#(
    parameter int unsigned               wordsize       = 8,
    parameter int unsigned               base_addr_size = 7,
    parameter logic [base_addr_size-1:0] base_addr      = 7'h00
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic [GPIO_WIDTH-1:0]     gpi,
    output logic [GPIO_WIDTH-1:0]     gpo
);

    logic                  sel;
    logic [1:0]            offset;
    logic [GPIO_WIDTH-1:0] gpi_sync;
    logic [GPIO_WIDTH-1:0] gpo_q;
    logic [BYTE_W-1:0]     rd_byte;
    logic [BYTE_W-1:0]     wr_byte;

    assign sel     = enable && (addr[base_addr_size-1:2] == base_addr[base_addr_size-1:2]);
    assign offset  = addr[1:0];
    assign wr_byte = BYTE_W'(data_in);

    reflet_sync2 #(
        .width (GPIO_WIDTH)
    ) u_gpi_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpi),
        .q     (gpi_sync)
    );

    // Zero when unselected so slaves can be OR-ed onto the CPU data input.
    always_comb begin
        rd_byte = '0;
        if (sel) begin
            case (offset)
                GPIO_IN_LO:  rd_byte = gpi_sync[7:0];
                GPIO_IN_HI:  rd_byte = gpi_sync[15:8];
                GPIO_OUT_LO: rd_byte = gpo_q[7:0];
                GPIO_OUT_HI: rd_byte = gpo_q[15:8];
                default:     rd_byte = '0;
            endcase
        end
    end

    assign data_out = wordsize'(rd_byte);

    // Byte-wise output register; writes to the input offsets fall through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpo_q <= '0;
        end else if (sel && write_en) begin
            case (offset)
                GPIO_OUT_LO: gpo_q[7:0]  <= wr_byte;
                GPIO_OUT_HI: gpo_q[15:8] <= wr_byte;
                default:     gpo_q       <= gpo_q;
            endcase
        end
    end

    assign gpo = gpo_q;

endmodule

// File: tb/tb_reflet_gpio_port.sv
// Directed self-checking bench for reflet_gpio_port with base_addr = 7'h10.
module tb_reflet_gpio_port;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [6:0]  addr;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] gpi;
    logic [15:0] gpo;

    int total;
    int bad;

    reflet_gpio_port #(
        .wordsize       (8),
        .base_addr_size (7),
        .base_addr      (7'h10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .gpi      (gpi),
        .gpo      (gpo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus write cycle; strobes drop 1 time unit after the writing edge.
    task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        enable   = 1'b1;
        addr     = a;
        write_en = 1'b1;
        data_in  = d;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        bus_write(7'h12, 8'h34);
        bus_write(7'h13, 8'h12);
        total++;
        if (gpo !== 16'h1234) begin
            bad++;
            $display("FAIL preload gpo got=%h want=%h", gpo, 16'h1234);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (gpo !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset gpo got=%h want=%h", gpo, 16'h0000);
        end
        enable = 1'b0;
        addr   = 7'h12;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_unsel data_out got=%h want=%h", data_out, 8'h00);
        end
        // Write attempt while reset is held must not land.
        @(negedge clk);
        enable = 1'b1; write_en = 1'b1; addr = 7'h12; data_in = 8'hAA;
        @(posedge clk);
        #1;
        total++;
        if (gpo !== 16'h0000) begin
            bad++;
            $display("FAIL reset_blocks_write gpo got=%h want=%h", gpo, 16'h0000);
        end
        write_en = 1'b0;
        addr     = 7'h10;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_sync_read data_out got=%h want=%h", data_out, 8'h00);
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write();
        bus_write(7'h13, 8'h80);
        total++;
        if (gpo !== 16'h8000) begin
            bad++;
            $display("FAIL write_hi gpo got=%h want=%h", gpo, 16'h8000);
        end
        bus_write(7'h12, 8'h0F);
        total++;
        if (gpo !== 16'h800F) begin
            bad++;
            $display("FAIL write_lo gpo got=%h want=%h", gpo, 16'h800F);
        end
        enable = 1'b1; addr = 7'h12;
        #1;
        total++;
        if (data_out !== 8'h0F) begin
            bad++;
            $display("FAIL read_off2 data_out got=%h want=%h", data_out, 8'h0F);
        end
        addr = 7'h13;
        #1;
        total++;
        if (data_out !== 8'h80) begin
            bad++;
            $display("FAIL read_off3 data_out got=%h want=%h", data_out, 8'h80);
        end
        enable = 1'b0;
    endtask

    task automatic test_input();
        @(negedge clk);
        gpi = 16'hABCD;
        @(posedge clk);
        #1;
        enable = 1'b1; addr = 7'h10;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL gpi_1edge_lo data_out got=%h want=%h", data_out, 8'h00);
        end
        addr = 7'h11;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL gpi_1edge_hi data_out got=%h want=%h", data_out, 8'h00);
        end
        @(posedge clk);
        #1;
        addr = 7'h10;
        #1;
        total++;
        if (data_out !== 8'hCD) begin
            bad++;
            $display("FAIL gpi_2edge_lo data_out got=%h want=%h", data_out, 8'hCD);
        end
        addr = 7'h11;
        #1;
        total++;
        if (data_out !== 8'hAB) begin
            bad++;
            $display("FAIL gpi_2edge_hi data_out got=%h want=%h", data_out, 8'hAB);
        end
        // Raw gpi change is not visible through the read path.
        gpi = 16'h1234;
        #1;
        total++;
        if (data_out !== 8'hAB) begin
            bad++;
            $display("FAIL gpi_raw_hidden data_out got=%h want=%h", data_out, 8'hAB);
        end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_isolation();
        @(negedge clk);
        enable = 1'b0; write_en = 1'b1; addr = 7'h12; data_in = 8'hFF;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL iso_data_out data_out got=%h want=%h", data_out, 8'h00);
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        total++;
        if (gpo !== 16'h800F) begin
            bad++;
            $display("FAIL iso_no_write gpo got=%h want=%h", gpo, 16'h800F);
        end
        bus_write(7'h10, 8'h55);
        total++;
        if (gpo !== 16'h800F) begin
            bad++;
            $display("FAIL ro_write gpo got=%h want=%h", gpo, 16'h800F);
        end
        enable = 1'b1; addr = 7'h10;
        #1;
        total++;
        if (data_out !== 8'h34) begin
            bad++;
            $display("FAIL ro_readback data_out got=%h want=%h", data_out, 8'h34);
        end
        enable = 1'b0;
    endtask

    task automatic test_decode();
        bus_write(7'h02, 8'h5A);
        total++;
        if (gpo !== 16'h800F) begin
            bad++;
            $display("FAIL decode_miss_write gpo got=%h want=%h", gpo, 16'h800F);
        end
        enable = 1'b1; addr = 7'h02;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL decode_miss_read data_out got=%h want=%h", data_out, 8'h00);
        end
        addr = 7'h16;
        #1;
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL decode_above_read data_out got=%h want=%h", data_out, 8'h00);
        end
        enable = 1'b0;
        bus_write(7'h12, 8'hC3);
        total++;
        if (gpo !== 16'h80C3) begin
            bad++;
            $display("FAIL decode_hit_write gpo got=%h want=%h", gpo, 16'h80C3);
        end
    endtask

    task automatic test_reset_mid();
        bus_write(7'h13, 8'h11);
        total++;
        if (gpo !== 16'h11C3) begin
            bad++;
            $display("FAIL mid_first_write gpo got=%h want=%h", gpo, 16'h11C3);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (gpo !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset gpo got=%h want=%h", gpo, 16'h0000);
        end
        // Write held across reset release: only the first edge with reset low counts.
        @(negedge clk);
        enable = 1'b1; write_en = 1'b1; addr = 7'h12; data_in = 8'h77;
        @(posedge clk);
        #1;
        total++;
        if (gpo !== 16'h0000) begin
            bad++;
            $display("FAIL mid_held_write gpo got=%h want=%h", gpo, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b0; write_en = 1'b0;
        total++;
        if (gpo !== 16'h0077) begin
            bad++;
            $display("FAIL mid_release_write gpo got=%h want=%h", gpo, 16'h0077);
        end
        bus_write(7'h13, 8'h22);
        total++;
        if (gpo !== 16'h2277) begin
            bad++;
            $display("FAIL mid_after_write gpo got=%h want=%h", gpo, 16'h2277);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        addr     = 7'h00;
        write_en = 1'b0;
        data_in  = 8'h00;
        gpi      = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (gpo !== 16'h0000) begin
            bad++;
            $display("FAIL initial_gpo gpo got=%h want=%h", gpo, 16'h0000);
        end

        test_reset();
        test_write();
        test_input();
        test_isolation();
        test_decode();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
